// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x WIDTH integer register file with a per-register busy scoreboard.
//   It holds the architectural registers x0..x31 and provides two read ports
//   with a same-cycle write-through bypass, plus a registered debug port.
//   It tracks destinations that are still in flight and raises a stall on a
//   RAW or WAW hazard.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   ra1/ra2 -> rd1/rd2    bypassed combinational reads (x0 reads as 0)
//   we, wa, wd            writeback; clears busy[wa]
//   iss_*                 issue request; stall is combinational
//   dbg_sel -> dbg_data   registered debug read, 1-cycle latency, no bypass
//   busy_cnt              registered population count of the busy vector
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             iss_valid,
  input  logic             iss_use1,
  input  logic             iss_use2,
  input  logic             iss_wr,
  input  logic [4:0]       iss_rd,
  output logic             stall,
  input  logic [4:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [5:0]       busy_cnt
);

  logic [NREG-1:0][WIDTH-1:0] r_regs;
  logic [NREG-1:0]            r_busy;
  logic [WIDTH-1:0]           r_dbg;
  logic [5:0]                 r_cnt;

  logic [NREG-1:0] w_clr;       // one-hot writeback clear (never bit 0)
  logic [NREG-1:0] w_set;       // one-hot issue set (never bit 0)
  logic [NREG-1:0] w_busy_nxt;
  logic [5:0]      w_cnt_nxt;
  logic            w_raw1, w_raw2, w_waw, w_issue;

  // Per-register decode of the writeback and issue targets.
  for (genvar g = 0; g < NREG; g++) begin : g_dec
    if (g == 0) begin : g_x0
      assign w_clr[g] = 1'b0;
      assign w_set[g] = 1'b0;
    end else begin : g_xn
      assign w_clr[g] = we && (wa == 5'(g));
      assign w_set[g] = w_issue && (iss_rd == 5'(g));
    end
  end

  // A writeback in the same cycle resolves the hazard. busy[0] is never set,
  // so index 0 cannot stall.
  assign w_raw1  = iss_use1 && r_busy[ra1] && !w_clr[ra1];
  assign w_raw2  = iss_use2 && r_busy[ra2] && !w_clr[ra2];
  assign w_waw   = iss_wr && (iss_rd != 5'd0) && r_busy[iss_rd] && !w_clr[iss_rd];
  assign stall   = iss_valid && (w_raw1 || w_raw2 || w_waw);
  assign w_issue = iss_valid && !stall && iss_wr && (iss_rd != 5'd0);

  // The set is OR'd in after the clear, so a new producer keeps the bit.
  assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) w_cnt_nxt = w_cnt_nxt + 6'(w_busy_nxt[i]);
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : w_clr[ra1] ? wd : r_regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : w_clr[ra2] ? wd : r_regs[ra2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
      r_dbg  <= '0;
      r_cnt  <= '0;
    end else begin
      // dbg samples the old contents: the write below lands at the same edge.
      r_dbg  <= (dbg_sel == 5'd0) ? '0 : r_regs[dbg_sel];
      if (we && wa != 5'd0) r_regs[wa] <= wd;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign dbg_data = r_dbg;
  assign busy_cnt = r_cnt;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32 x WIDTH integer register file with a per-register busy scoreboard, for the RISC-V pipeline.
- Sits directly upstream of the 32-way read-select muxes in decode.
  - Holds the architectural registers x0..x31.
  - Provides two bypassed read ports and a debug read port.
- Tracks in-flight destination registers and raises a stall when an issuing instruction has a RAW or WAW hazard.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers. Fixed at 32 because the select fields are 5 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  5  read address, port 1 (rs1).
- ra2  input  5  read address, port 2 (rs2).
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).
- we  input  1  writeback enable.
- wa  input  5  writeback address.
- wd  input  WIDTH  writeback data.
- iss_valid  input  1  an instruction is attempting to issue this cycle.
- iss_use1  input  1  issuing instruction reads ra1.
- iss_use2  input  1  issuing instruction reads ra2.
- iss_wr  input  1  issuing instruction writes a destination.
- iss_rd  input  5  destination of the issuing instruction.
- stall  output  1  issue blocked this cycle (combinational).
- dbg_sel  input  5  debug register select.
- dbg_data  output  WIDTH  debug read data (registered, 1-cycle latency).
- busy_cnt  output  6  number of busy registers (registered).

Behaviour:
- Reset (rst=1 at an edge), including mid-operation:
  - All registers become 0 and all busy bits clear.
  - dbg_data becomes 0 and busy_cnt becomes 0.
  - Any in-flight write in that same cycle is discarded.
- x0:
  - Reads always return 0.
  - Writes to address 0 are ignored.
  - busy[0] is never set.
- Write:
  - At an edge with we=1 and wa!=0, reg[wa] <= wd.
  - busy[wa] clears unless it is re-set by an issue in the same cycle (see simultaneous events).
- Read:
  - rdN = 0 if raN==0.
  - Else rdN = wd if we=1 and wa==raN (write-through bypass, same cycle).
  - Else rdN = reg[raN].
- Hazards. wclr(i) is defined as (we=1 and wa==i).
  - raw1 = iss_use1 and busy[ra1] and !wclr(ra1).
  - raw2 = iss_use2 and busy[ra2] and !wclr(ra2).
  - waw = iss_wr and iss_rd!=0 and busy[iss_rd] and !wclr(iss_rd).
  - stall = iss_valid and (raw1 or raw2 or waw).
  - A writeback in the same cycle resolves the hazard.
  - Address 0 never causes a hazard.
- Issue: at an edge with iss_valid=1, stall=0, iss_wr=1 and iss_rd!=0, busy[iss_rd] <= 1.
- Simultaneous events: if a set and a clear target the same index in the same cycle, the set wins and busy stays 1 for the new producer.
- busy_cnt:
  - Updated each edge to the population count of the next-state busy vector.
  - Range 0..31; it cannot overflow.
- dbg_data:
  - Registered each edge.
  - Value is 0 if dbg_sel==0, else reg[dbg_sel] before the write of that edge (no bypass).
  - No effect on other state.
- No stall or clear occurs without its qualifying input; a writeback to a non-busy register is legal and leaves busy unchanged.

Test Plan:
1. Reset then read all addresses -> rd1=rd2=0 for all 32 addresses; busy_cnt=0; stall=0 for any issue.
2. Write x0: we=1, wa=0, wd=32'hDEADBEEF; ra1=0 -> rd1=0 during and after the write; dbg_sel=0 gives dbg_data=0 next cycle.
3. Bypass: we=1, wa=5, wd=32'h12345678, ra1=5 -> rd1=32'h12345678 in the same cycle; the next cycle (we=0) still returns 32'h12345678; dbg_sel=5 gives dbg_data=32'h12345678 one cycle later.
4. RAW stall:
   - Issue iss_wr=1, iss_rd=7 -> busy_cnt=1 next cycle.
   - Then issue with iss_use2=1, ra2=7 -> stall=1.
   - Assert we=1, wa=7 in that cycle -> stall=0, busy_cnt=0 next cycle.
5. Simultaneous set and clear: busy[9]=1; same cycle we=1, wa=9 and a non-stalled issue with iss_rd=9 -> busy[9] remains 1; busy_cnt unchanged; a following read of x9 with iss_use1 stalls.
6. Reset mid-operation: busy on x3 and x4, rst=1 with we=1, wa=3 in the same cycle -> after the edge busy_cnt=0, reg[3]=0, stall=0.
